// File: rtl/comparator_16b_pkg.sv
// Shared constants for the registered unsigned magnitude comparator:
// default width, slice width and the one-hot {gt, eq, lt} result codes.
package comparator_16b_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int NIB           = 4;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // Only consulted for a slice known to differ, so gt alone picks the code.
  function automatic logic [2:0] slice_code(input logic gt);
    return gt ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/comparator_4b.sv
// Purely combinational 4-bit unsigned compare; one leaf slice of the cascade.
module comparator_4b
  import comparator_16b_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  output logic           gt,
  output logic           eq,
  output logic           lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/comparator_16b.sv
// Registered unsigned magnitude comparator: nibble slices resolved MSB-first,
// one-hot {gt, eq, lt} captured every cycle, all-zero while in reset.
module comparator_16b
  import comparator_16b_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int N_SLICES = WIDTH / NIB;

  logic [N_SLICES-1:0] slice_gt;
  logic [N_SLICES-1:0] slice_eq;
  logic [N_SLICES-1:0] slice_lt;

  logic [2:0] result_next;
  logic [2:0] result_reg;

  generate
    for (genvar gi = 0; gi < N_SLICES; gi++) begin : g_slice
      comparator_4b u_slice (
        .a  (data_a[gi*NIB +: NIB]),
        .b  (data_b[gi*NIB +: NIB]),
        .gt (slice_gt[gi]),
        .eq (slice_eq[gi]),
        .lt (slice_lt[gi])
      );
    end
  endgenerate

  // Walk LSB to MSB so each higher differing slice overrides the lower ones;
  // the most-significant unequal slice therefore decides the result.
  always_comb begin
    result_next = RES_EQ;
    for (int i = 0; i < N_SLICES; i++) begin
      if (!slice_eq[i]) begin
        result_next = slice_code(slice_gt[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= RES_NONE;
    end else begin
      result_reg <= result_next;
    end
  end

  assign a_gt_b = result_reg[2];
  assign a_eq_b = result_reg[1];
  assign a_lt_b = result_reg[0];

  // slice_lt is implied by the gt/eq pair; kept for completeness of the slice interface.
  logic unused_lt;
  assign unused_lt = ^slice_lt;

endmodule

// File: tb/tb_comparator_16b.sv
// Directed and random checks of the registered 16-bit comparator against
// hand-computed codes and a plain full-width reference compare.
module tb_comparator_16b;

  logic        clk;
  logic        rst;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic        a_gt_b;
  logic        a_eq_b;
  logic        a_lt_b;
  logic [2:0]  obs;

  int total;
  int bad;

  comparator_16b #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_a (data_a),
    .data_b (data_b),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b)
  );

  assign obs = {a_gt_b, a_eq_b, a_lt_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands, let one edge capture them, then settle 1 time unit past it.
  task automatic cycle(input logic [15:0] a, input logic [15:0] b);
    data_a = a;
    data_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(16'h04F8, 16'h04F7);
      total++;
      $display("txn reset[%0d] a=%h b=%h out=%b", i, data_a, data_b, obs);
      if (obs !== 3'b000) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %b want 000", i, obs);
      end
    end
    rst = 1'b0;
    cycle(16'h04F8, 16'h04F7);
    total++;
    $display("txn reset_release a=%h b=%h out=%b", data_a, data_b, obs);
    if (obs !== 3'b100) begin
      bad++;
      $display("FAIL reset_release: got %b want 100", obs);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] va [4] = '{16'h04F8, 16'h04F8, 16'h04FA, 16'h04FA};
    logic [15:0] vb [4] = '{16'h04F7, 16'h04FA, 16'h04FA, 16'h24FA};
    logic [2:0]  ve [4] = '{3'b100, 3'b001, 3'b010, 3'b001};
    for (int i = 0; i < 4; i++) begin
      cycle(va[i], vb[i]);
      total++;
      $display("txn seq[%0d] a=%h b=%h out=%b", i, va[i], vb[i], obs);
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL seq[%0d]: a=%h b=%h got %b want %b", i, va[i], vb[i], obs, ve[i]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [15:0] va [6] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'h1F00};
    logic [15:0] vb [6] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h2000};
    logic [2:0]  ve [6] = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 6; i++) begin
      cycle(va[i], vb[i]);
      total++;
      $display("txn ext[%0d] a=%h b=%h out=%b", i, va[i], vb[i], obs);
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL ext[%0d]: a=%h b=%h got %b want %b", i, va[i], vb[i], obs, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Each pair differs from the last only in a single nibble to exercise every slice.
    logic [15:0] va [5] = '{16'h1234, 16'h1235, 16'h1244, 16'h1334, 16'h2234};
    logic [15:0] vb [5] = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
    logic [2:0]  ve [5] = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    for (int i = 0; i < 5; i++) begin
      cycle(vb[i], va[i]);
      total++;
      $display("txn b2b[%0d] a=%h b=%h out=%b", i, vb[i], va[i], obs);
      if (obs !== {ve[i][0], ve[i][1], ve[i][2]}) begin
        bad++;
        $display("FAIL b2b[%0d]: a=%h b=%h got %b want %b", i, vb[i], va[i], obs,
                 {ve[i][0], ve[i][1], ve[i][2]});
      end
    end
  endtask

  task automatic test_mid_reset();
    cycle(16'h0001, 16'h0000);
    total++;
    $display("txn mid_pre a=%h b=%h out=%b", data_a, data_b, obs);
    if (obs !== 3'b100) begin
      bad++;
      $display("FAIL mid_pre: got %b want 100", obs);
    end
    rst = 1'b1;
    cycle(16'h0001, 16'h0000);
    total++;
    $display("txn mid_rst a=%h b=%h out=%b", data_a, data_b, obs);
    if (obs !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst: got %b want 000", obs);
    end
    rst = 1'b0;
    cycle(16'h0001, 16'h0000);
    total++;
    $display("txn mid_release a=%h b=%h out=%b", data_a, data_b, obs);
    if (obs !== 3'b100) begin
      bad++;
      $display("FAIL mid_release: got %b want 100", obs);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp;
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      else if ($urandom_range(0, 7) == 0) b = a ^ (16'h1 << $urandom_range(0, 15));
      exp = (a > b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
      cycle(a, b);
      total++;
      $display("txn rnd[%0d] a=%h b=%h out=%b", i, a, b, obs);
      if (obs !== exp || $countones(obs) != 1) begin
        bad++;
        $display("FAIL rnd[%0d]: a=%h b=%h got %b want %b", i, a, b, obs, exp);
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    data_a = '0;
    data_b = '0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_extremes();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_16b.md
Name: comparator_16b

Overview:
- Registered 16-bit unsigned magnitude comparator.
- Compares data_a against data_b and reports a one-hot result: greater-than, equal or less-than.
- Used as a leaf datapath block wherever ordering of two 16-bit unsigned quantities is needed.
- One clock domain; synchronous active-high reset; result available one clock after the operands are sampled.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4; only 16 is verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_a  input  WIDTH  operand A, unsigned.
- data_b  input  WIDTH  operand B, unsigned.
- a_gt_b  output  1  registered; 1 when A > B.
- a_eq_b  output  1  registered; 1 when A == B.
- a_lt_b  output  1  registered; 1 when A < B.

Interface decision (already decided): one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Comparison is unsigned and over the full WIDTH.
- No sign interpretation: 16'h8000 > 16'h7FFF.
- Combinational compare of data_a and data_b is captured into the three output flops on every rising clk edge when rst = 0.
  - Latency: exactly 1 cycle.
  - Outputs at cycle n+1 reflect the operands present at edge n.
  - No enable and no handshake; a new compare is taken every cycle.
- Outputs are one-hot after the first non-reset edge: exactly one of a_gt_b, a_eq_b, a_lt_b is 1.
- Reset:
  - When rst = 1 at a rising edge, all three outputs go to 0, regardless of operands.
  - The all-zero state denotes "no valid result" and occurs only during and after reset, until the first edge with rst = 0.
- Reset mid-operation: any pending result is discarded. The first edge with rst = 0 loads a fresh compare of the operands present at that edge.
- Boundaries:
  - A = B = 0 gives eq.
  - A = B = 16'hFFFF gives eq.
  - 16'hFFFF vs 0 gives gt.
  - 0 vs 16'hFFFF gives lt.
  - A difference in bit 0 only is resolved correctly, e.g. 16'h04F8 vs 16'h04F7.
- Structure:
  - Compare is built MSB-first from WIDTH/4 nibble slices.
  - Each slice produces local gt/eq/lt.
  - Cascade rule: the result is that of the most-significant slice whose eq = 0; if all slices are equal, the result is eq.
  - The combinational path must not use the built-in > or < on the full width; nibble slices may use them.
- No X propagation on valid inputs. If an input is X, the outputs are unspecified and are not checked.

Decomposition:
- Shared package: parameter default WIDTH = 16; a localparam for the nibble width NIB = 4.
- Result encoding constants (3-bit one-hot gt/eq/lt):
  - RES_GT = 3'b100
  - RES_EQ = 3'b010
  - RES_LT = 3'b001
  - RES_NONE = 3'b000
- One sub-module, comparator_4b: purely combinational 4-bit unsigned compare with outputs gt, eq, lt. Instantiated WIDTH/4 times.
- The top level does the MSB-first cascade and the output register.

Test Plan:
- Reset: rst = 1 for 2 cycles with A = 16'h04F8, B = 16'h04F7 -> gt/eq/lt = 0/0/0 throughout reset. On the first edge with rst = 0 they load, and the next cycle reads 1/0/0.
- Sequential stimulus, one cycle apart, each checked one cycle later:
  - A = 16'h04F8, B = 16'h04F7 -> gt = 1.
  - B = 16'h04FA -> lt = 1.
  - A = 16'h04FA -> eq = 1.
  - B = 16'h24FA -> lt = 1.
- Extremes:
  - A = 16'hFFFF, B = 16'h0000 -> gt.
  - Swap the operands -> lt.
  - A = B = 16'h0000 -> eq.
  - A = B = 16'hFFFF -> eq.
- Cascade/MSB priority:
  - A = 16'h8000, B = 16'h7FFF -> gt (unsigned, top nibble wins).
  - A = 16'h1F00, B = 16'h2000 -> lt.
- Mid-run reset: drive A = 16'h0001, B = 16'h0000, then assert rst for 1 cycle -> outputs 0/0/0 in the cycle after the reset edge, then 1/0/0 once released.
- Random: 10,000 random A/B pairs -> each result one-hot and equal to the reference compare of the previous cycle's operands.
